ez8_loader: RTL and testbench

EZ8_LOADER -- requirements
Module: ez8_loader

---
 rtl/ez8_loader_pkg.sv | 34 +++
 rtl/ez8_loader_watchdog.sv | 39 +++
 rtl/ez8_loader.sv | 162 ++++++++++++++++
 tb/tb_ez8_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ez8_loader_pkg.sv
// Shared definitions for the EZ8 program loader: FSM state encoding and
// the stream field widths used by the loader and its bench.
package ez8_loader_pkg;

   localparam int BYTE_W    = 8;
   localparam int HDR_W     = 16;
   localparam int LEN_W     = 12;
   localparam int CSUM_W    = 8;
   localparam int MAX_WORDS = 4096;
   localparam int ADDR_W    = $clog2(MAX_WORDS);
   localparam int DATA_W    = 2 * BYTE_W;
   localparam int WC_W      = $clog2(MAX_WORDS) + 1;
   // Header byte 0 only contributes its low nibble to the length field.
   localparam int LEN_HI_W  = LEN_W - BYTE_W;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA_HI,
      ST_DATA_LO,
      ST_CSUM,
      ST_RST_CPU,
      ST_RUN,
      ST_HALT,
      ST_ERR
   } state_e;

   function automatic logic is_loading(state_e s);
      return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
             (s == ST_DATA_LO) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/ez8_loader_watchdog.sv
// Idle-cycle watchdog for the loader: counts enabled cycles since the last
// clear and flags expiry on the TIMEOUT-th such cycle.
module ez8_loader_watchdog #(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

   // The count holds at its terminal value so it never wraps while the
   // loader is still reacting to expiry.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ez8_loader.sv
// EZ8 program loader: receives a length-prefixed, checksummed word stream,
// writes it into instruction memory, then releases and supervises the core.
module ez8_loader
   import ez8_loader_pkg::*;
#(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              pause_req,
   input  logic              cpu_stopped,
   input  logic              cpu_error,
   output logic              cpu_reset,
   output logic              cpu_pause,
   output logic [ADDR_W-1:0] instr_writeaddr,
   output logic [DATA_W-1:0] instr_writedata,
   output logic              instr_write_en,
   output logic              busy,
   output logic              done,
   output logic              load_error,
   output logic [WC_W-1:0]   word_count
);

   state_e                state_q;
   logic                  cpu_reset_q;
   logic                  wr_en_q;
   logic [ADDR_W-1:0]     wr_addr_q;
   logic [DATA_W-1:0]     wr_data_q;
   logic                  done_q;
   logic                  err_q;
   logic [WC_W-1:0]       wc_q;
   logic [LEN_HI_W-1:0]   len_hi_q;
   logic [ADDR_W-1:0]     last_idx_q;
   logic [BYTE_W-1:0]     data_hi_q;
   logic [CSUM_W-1:0]     csum_q;
   logic                  rst_cnt_q;

   logic loading;
   logic accept;
   logic wd_expired;

   assign loading = is_loading(state_q);
   assign accept  = loading && rx_valid;

   ez8_loader_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (accept || !loading),
      .enable  (loading),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cpu_reset_q <= 1'b1;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         wc_q        <= '0;
         len_hi_q    <= '0;
         last_idx_q  <= '0;
         data_hi_q   <= '0;
         csum_q      <= '0;
         rst_cnt_q   <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_RUN, ST_HALT, ST_ERR: begin
               if (start) begin
                  state_q     <= ST_LEN_HI;
                  cpu_reset_q <= 1'b1;
                  wc_q        <= '0;
                  csum_q      <= '0;
                  done_q      <= 1'b0;
                  err_q       <= 1'b0;
               end else if (state_q == ST_RUN) begin
                  // A core fault outranks a simultaneous stop report.
                  if (cpu_error) begin
                     state_q     <= ST_ERR;
                     cpu_reset_q <= 1'b1;
                     err_q       <= 1'b1;
                  end else if (cpu_stopped) begin
                     state_q <= ST_HALT;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM: begin
               if (accept) begin
                  case (state_q)
                     ST_LEN_HI: begin
                        len_hi_q <= rx_data[LEN_HI_W-1:0];
                        state_q  <= ST_LEN_LO;
                     end
                     ST_LEN_LO: begin
                        last_idx_q <= {len_hi_q, rx_data};
                        state_q    <= ST_DATA_HI;
                     end
                     ST_DATA_HI: begin
                        data_hi_q <= rx_data;
                        csum_q    <= csum_q ^ rx_data;
                        state_q   <= ST_DATA_LO;
                     end
                     ST_DATA_LO: begin
                        csum_q    <= csum_q ^ rx_data;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wc_q[ADDR_W-1:0];
                        wr_data_q <= {data_hi_q, rx_data};
                        wc_q      <= wc_q + WC_W'(1);
                        state_q   <= (wc_q[ADDR_W-1:0] == last_idx_q) ? ST_CSUM : ST_DATA_HI;
                     end
                     default: begin
                        if (rx_data == csum_q) begin
                           state_q   <= ST_RST_CPU;
                           rst_cnt_q <= 1'b0;
                        end else begin
                           state_q <= ST_ERR;
                           err_q   <= 1'b1;
                        end
                     end
                  endcase
               end else if (wd_expired) begin
                  state_q <= ST_ERR;
                  err_q   <= 1'b1;
               end
            end
            ST_RST_CPU: begin
               if (rst_cnt_q) begin
                  state_q     <= ST_RUN;
                  cpu_reset_q <= 1'b0;
               end else begin
                  rst_cnt_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               cpu_reset_q <= 1'b1;
            end
         endcase
      end
   end

   // Pause follows the debugger directly while running; otherwise the core is held.
   assign cpu_pause       = (state_q == ST_RUN) ? pause_req : 1'b1;
   assign cpu_reset       = cpu_reset_q;
   assign rx_ready        = loading;
   assign busy            = loading || (state_q == ST_RST_CPU);
   assign instr_write_en  = wr_en_q;
   assign instr_writeaddr = wr_addr_q;
   assign instr_writedata = wr_data_q;
   assign done            = done_q;
   assign load_error      = err_q;
   assign word_count      = wc_q;

endmodule

// File: tb/tb_ez8_loader.sv
// Self-checking bench for ez8_loader: a stream-position model checks every
// output each cycle, and directed scenarios pin the model with literals.
module tb_ez8_loader;

   // A short watchdog keeps the expiry scenarios fast; the behaviour is length-independent.
   localparam int TO = 40;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        pause_req;
   logic        cpu_stopped;
   logic        cpu_error;
   logic        cpu_reset;
   logic        cpu_pause;
   logic [11:0] instr_writeaddr;
   logic [15:0] instr_writedata;
   logic        instr_write_en;
   logic        busy;
   logic        done;
   logic        load_error;
   logic [12:0] word_count;

   int nChecks = 0;
   int nPass   = 0;

   logic [27:0] wlog[$];

   ez8_loader #(.TIMEOUT(TO)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .rx_ready        (rx_ready),
      .pause_req       (pause_req),
      .cpu_stopped     (cpu_stopped),
      .cpu_error       (cpu_error),
      .cpu_reset       (cpu_reset),
      .cpu_pause       (cpu_pause),
      .instr_writeaddr (instr_writeaddr),
      .instr_writedata (instr_writedata),
      .instr_write_en  (instr_write_en),
      .busy            (busy),
      .done            (done),
      .load_error      (load_error),
      .word_count      (word_count)
   );

   always #5 clk = ~clk;

   function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         nPass++;
      end
   endfunction

   // Reference model: tracks position within the byte stream rather than loader states.
   typedef enum {M_IDLE, M_LOAD, M_RST, M_RUN, M_HALT, M_ERR} mode_t;
   mode_t       mMode;
   int          mPos, mWords, mIdle, mRstLeft, mWc;
   logic [7:0]  mHdr, mXor, mHi;
   logic        mDone, mErr, mWrEn;
   logic [11:0] mWrAddr;
   logic [15:0] mWrData;

   task automatic modelReset();
      mMode = M_IDLE; mPos = 0; mWords = 1; mIdle = 0; mRstLeft = 0; mWc = 0;
      mHdr = 8'h00; mXor = 8'h00; mHi = 8'h00;
      mDone = 1'b0; mErr = 1'b0; mWrEn = 1'b0; mWrAddr = 12'h000; mWrData = 16'h0000;
   endtask

   task automatic modelStep();
      mWrEn = 1'b0;
      case (mMode)
         M_LOAD: begin
            if (rx_valid) begin
               mIdle = 0;
               if (mPos == 0) begin
                  mHdr = rx_data;
               end else if (mPos == 1) begin
                  mWords = int'({mHdr[3:0], rx_data}) + 1;
               end else if (mPos < 2 + 2 * mWords) begin
                  mXor = mXor ^ rx_data;
                  if (mPos % 2 == 0) begin
                     mHi = rx_data;
                  end else begin
                     mWrEn = 1'b1; mWrAddr = 12'((mPos - 3) / 2); mWrData = {mHi, rx_data}; mWc++;
                  end
               end else if (rx_data == mXor) begin
                  mMode = M_RST; mRstLeft = 2;
               end else begin
                  mMode = M_ERR; mErr = 1'b1;
               end
               mPos++;
            end else begin
               mIdle++;
               if (mIdle >= TO) begin mMode = M_ERR; mErr = 1'b1; end
            end
         end
         M_RST: begin
            mRstLeft--;
            if (mRstLeft == 0) mMode = M_RUN;
         end
         default: begin
            if (start) begin
               mMode = M_LOAD; mPos = 0; mXor = 8'h00; mWc = 0; mDone = 1'b0; mErr = 1'b0; mIdle = 0;
            end else if (mMode == M_RUN) begin
               if (cpu_error) begin mMode = M_ERR; mErr = 1'b1; end
               else if (cpu_stopped) begin mMode = M_HALT; mDone = 1'b1; end
            end
         end
      endcase
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) modelReset();
      else        modelStep();
   end

   // Every cycle, compare all outputs against the model.
   always @(negedge clk) begin
      checkOutput("rx_ready",   32'(rx_ready),   32'(mMode == M_LOAD));
      checkOutput("busy",       32'(busy),       32'(mMode == M_LOAD || mMode == M_RST));
      checkOutput("cpu_reset",  32'(cpu_reset),  32'(!(mMode == M_RUN || mMode == M_HALT)));
      checkOutput("cpu_pause",  32'(cpu_pause),  32'((mMode == M_RUN) ? pause_req : 1'b1));
      checkOutput("done",       32'(done),       32'(mDone));
      checkOutput("load_error", 32'(load_error), 32'(mErr));
      checkOutput("word_count", 32'(word_count), 32'(mWc));
      checkOutput("write_en",   32'(instr_write_en), 32'(mWrEn));
      if (mWrEn) begin
         checkOutput("write_addr", 32'(instr_writeaddr), 32'(mWrAddr));
         checkOutput("write_data", 32'(instr_writedata), 32'(mWrData));
      end
      if (!reset) begin
         checkOutput("reset_addr", 32'(instr_writeaddr), 32'h0);
         checkOutput("reset_data", 32'(instr_writedata), 32'h0);
      end
   end

   always @(negedge clk) begin
      if (instr_write_en === 1'b1) wlog.push_back({instr_writeaddr, instr_writedata});
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulseStart();
      rx_valid = 1'b0;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Offer one byte after an idle gap and hold it until the loader takes it.
   task automatic applyStimulus(input logic [7:0] b, input int gap, input bit randStart);
      int   waited;
      logic ready;
      rx_valid = 1'b0;
      for (int i = 0; i < gap; i++) begin
         rx_data = 8'($urandom);
         start   = randStart && ($urandom_range(0, 7) == 0);
         tick(1);
      end
      start    = 1'b0;
      rx_valid = 1'b1;
      rx_data  = b;
      waited   = 0;
      forever begin
         ready = rx_ready;
         tick(1);
         if (ready) break;
         waited++;
         if (waited > 20) begin
            nChecks++;
            $display("[TB] FAIL handshake: byte 0x%0h not accepted within 20 cycles", b);
            break;
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic randomLoad(input int n, input logic [3:0] hdrUpper, input bit corrupt,
                             input int maxGap, output logic [15:0] lastWord);
      logic [7:0]  q[$];
      logic [7:0]  x, b;
      logic [11:0] len;
      len = 12'(n - 1);
      q.push_back({hdrUpper, len[11:8]});
      q.push_back(len[7:0]);
      x = 8'h00;
      lastWord = 16'h0000;
      for (int i = 0; i < 2 * n; i++) begin
         b = 8'($urandom);
         x = x ^ b;
         q.push_back(b);
         lastWord = {lastWord[7:0], b};
      end
      q.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
      foreach (q[i]) applyStimulus(q[i], $urandom_range(0, maxGap), i >= 2);
   endtask

   task automatic sendFixed(input logic [7:0] csum);
      logic [7:0] s[7];
      s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
      s[6] = csum;
      foreach (s[i]) applyStimulus(s[i], 0, 1'b0);
   endtask

   task automatic runPhase(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         pause_req   = 1'($urandom_range(0, 1));
         cpu_stopped = ($urandom_range(0, 19) == 0);
         cpu_error   = ($urandom_range(0, 29) == 0);
         tick(1);
      end
      pause_req = 1'b0; cpu_stopped = 1'b0; cpu_error = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      logic [15:0] lastWord;
      reset = 1'b0; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
      pause_req = 1'b0; cpu_stopped = 1'b0; cpu_error = 1'b0;
      tick(3);
      checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'h1);
      checkOutput("rst_cpu_pause", 32'(cpu_pause), 32'h1);
      checkOutput("rst_busy",      32'(busy),      32'h0);
      checkOutput("rst_wc",        32'(word_count), 32'h0);
      reset = 1'b1;
      tick(2);

      $display("[TB] basic two-word load");
      wlog.delete();
      pulseStart();
      sendFixed(8'h40);
      checkOutput("rstcpu1_busy", 32'(busy), 32'h1);
      checkOutput("rstcpu1_cpu_reset", 32'(cpu_reset), 32'h1);
      tick(1);
      checkOutput("rstcpu2_busy", 32'(busy), 32'h1);
      tick(1);
      checkOutput("writes_n", 32'(wlog.size()), 32'd2);
      if (wlog.size() == 2) begin
         checkOutput("write0", 32'(wlog[0]), 32'h000_1234);
         checkOutput("write1", 32'(wlog[1]), 32'h001_ABCD);
      end
      checkOutput("run_cpu_reset", 32'(cpu_reset), 32'h0);
      checkOutput("run_busy", 32'(busy), 32'h0);
      checkOutput("run_wc", 32'(word_count), 32'd2);

      $display("[TB] run / pause / halt");
      pause_req = 1'b1; #1;
      checkOutput("pause_on", 32'(cpu_pause), 32'h1);
      pause_req = 1'b0; #1;
      checkOutput("pause_off", 32'(cpu_pause), 32'h0);
      cpu_stopped = 1'b1; tick(1); cpu_stopped = 1'b0;
      tick(3);
      checkOutput("halt_done", 32'(done), 32'h1);
      checkOutput("halt_cpu_reset", 32'(cpu_reset), 32'h0);
      pulseStart();
      checkOutput("reload_cpu_reset", 32'(cpu_reset), 32'h1);
      checkOutput("reload_done", 32'(done), 32'h0);

      $display("[TB] bad checksum");
      sendFixed(8'h41);
      tick(5);
      checkOutput("err_flag", 32'(load_error), 32'h1);
      checkOutput("err_cpu_reset", 32'(cpu_reset), 32'h1);
      pulseStart();
      checkOutput("err_cleared", 32'(load_error), 32'h0);

      $display("[TB] watchdog expiry");
      applyStimulus(8'h00, 0, 1'b0);
      applyStimulus(8'h00, 0, 1'b0);
      tick(TO - 1);
      checkOutput("wd_before", 32'(load_error), 32'h0);
      tick(1);
      checkOutput("wd_expired", 32'(load_error), 32'h1);
      checkOutput("wd_ready", 32'(rx_ready), 32'h0);

      $display("[TB] watchdog survives TIMEOUT-1 idle cycles");
      pulseStart();
      applyStimulus(8'h00, 0, 1'b0);
      applyStimulus(8'h00, 0, 1'b0);
      applyStimulus(8'h55, TO - 1, 1'b0);
      applyStimulus(8'hAA, 0, 1'b0);
      applyStimulus(8'hFF, 0, 1'b0);
      tick(3);
      checkOutput("wd_ok_error", 32'(load_error), 32'h0);
      checkOutput("wd_ok_run", 32'(cpu_reset), 32'h0);

      $display("[TB] reset mid-load");
      wlog.delete();
      pulseStart();
      applyStimulus(8'h00, 0, 1'b0);
      applyStimulus(8'h03, 0, 1'b0);
      applyStimulus(8'h11, 0, 1'b0);
      applyStimulus(8'h22, 0, 1'b0);
      applyStimulus(8'h33, 0, 1'b0);
      rx_valid = 1'b1; rx_data = 8'h44;
      reset = 1'b0; #1;
      checkOutput("mid_rst_we", 32'(instr_write_en), 32'h0);
      checkOutput("mid_rst_wc", 32'(word_count), 32'h0);
      checkOutput("mid_rst_busy", 32'(busy), 32'h0);
      checkOutput("mid_rst_cpu_reset", 32'(cpu_reset), 32'h1);
      tick(2);
      reset = 1'b1;
      tick(5);
      rx_valid = 1'b0;
      checkOutput("mid_rst_writes", 32'(wlog.size()), 32'd1);

      $display("[TB] maximum-length load");
      wlog.delete();
      pulseStart();
      randomLoad(4096, 4'h0, 1'b0, 1, lastWord);
      checkOutput("max_writes", 32'(wlog.size()), 32'd4096);
      if (wlog.size() == 4096) begin
         checkOutput("max_last_addr", 32'(wlog[4095][27:16]), 32'hFFF);
         checkOutput("max_last_data", 32'(wlog[4095][15:0]), 32'(lastWord));
      end
      checkOutput("max_wc", 32'(word_count), 32'd4096);
      tick(2);
      runPhase(20);

      $display("[TB] randomized loads");
      for (int it = 0; it < 25; it++) begin
         pulseStart();
         randomLoad($urandom_range(1, 20), 4'($urandom), ($urandom_range(0, 4) == 0), 3, lastWord);
         runPhase(40);
      end

      tick(2);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
